// File: rtl/strip_trig_pkg.sv
// Shared definitions for the strip trigger serializer.
// Holds the default field widths, the frame geometry helpers
// (word width, bits per lane, padded frame width) and the FSM state type.
package strip_trig_pkg;

  localparam int N_LANES_DEF = 2;
  localparam int BCID_W_DEF  = 12;
  localparam int PHI_W_DEF   = 5;
  localparam int BAND_W_DEF  = 8;

  function automatic int calc_word_w(input int bcid_w, input int phi_w, input int band_w);
    return bcid_w + phi_w + band_w;
  endfunction

  // Bits carried by each lane per frame: ceil(word_w / n_lanes).
  function automatic int calc_bpl(input int word_w, input int n_lanes);
    return (word_w + n_lanes - 1) / n_lanes;
  endfunction

  function automatic int calc_frame_w(input int word_w, input int n_lanes);
    return calc_bpl(word_w, n_lanes) * n_lanes;
  endfunction

  // Fixed encodings kept as plain constants so older code can compare against them.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_LOAD  = S_LOAD,
    ST_SHIFT = S_SHIFT,
    ST_GAP   = S_GAP
  } strip_trig_state_e;

endpackage

// File: rtl/strip_trig_fifo.sv
// Synchronous FIFO buffering trigger words ahead of the serializer.
// Ports:
//   clk_320M, reset : clock, synchronous active-high reset
//   push, wr_data   : write request and data (ignored when full)
//   pop             : remove head entry (ignored when empty)
//   rd_data         : current head entry (valid when !empty)
//   full, empty     : flags decoded from the registered occupancy count
module strip_trig_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4
) (
  input  logic             clk_320M,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_320M) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/strip_trigger_serializer_multi.sv
// Strip trigger serializer: buffers {BCID, phi, band} words and sends each
// one MSB-first across N_LANES lanes, framed by trig_en, with a fixed gap.
// Ports:
//   clk_320M, reset              : clock, synchronous active-high reset
//   load_input + field inputs    : word push (dropped and counted when !ready)
//   test_mode                    : send TEST_PATTERN frames when nothing is queued
//   ready                        : FIFO not full (registered count only)
//   busy                         : frame/gap in progress or words queued
//   trig_en, trig_d              : registered frame strobe and lane data
//   overflow_cnt                 : saturating count of dropped loads
//
// state | meaning
// IDLE  | nothing in flight; waits for a queued word or test_mode
// LOAD  | shift register holds the next frame; trig_en low for this cycle
// SHIFT | BPL cycles of lane data with trig_en high
// GAP   | GAP_CYCLES idle cycles; then next frame or back to IDLE
module strip_trigger_serializer_multi
  import strip_trig_pkg::*;
#(
  parameter int N_LANES    = N_LANES_DEF,
  parameter int BCID_W     = BCID_W_DEF,
  parameter int PHI_W      = PHI_W_DEF,
  parameter int BAND_W     = BAND_W_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 1,
  parameter logic [BCID_W+PHI_W+BAND_W-1:0] TEST_PATTERN = 25'h1555555
) (
  input  logic               clk_320M,
  input  logic               reset,
  input  logic               load_input,
  input  logic [BCID_W-1:0]  trigger_content_BCID_input,
  input  logic [PHI_W-1:0]   phi_id_input,
  input  logic [BAND_W-1:0]  bandid_input,
  input  logic               test_mode,
  output logic               ready,
  output logic               busy,
  output logic               trig_en,
  output logic [N_LANES-1:0] trig_d,
  output logic [15:0]        overflow_cnt
);

  localparam int WORD_W  = calc_word_w(BCID_W, PHI_W, BAND_W);
  localparam int BPL     = calc_bpl(WORD_W, N_LANES);
  localparam int FRAME_W = calc_frame_w(WORD_W, N_LANES);
  localparam int CNT_MAX = (BPL > GAP_CYCLES) ? BPL : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(BPL - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  strip_trig_state_e  state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic               trig_en_q, trig_en_d;
  logic [N_LANES-1:0] trig_d_q, trig_d_d;
  logic [15:0]        ovf_q, ovf_d;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [WORD_W-1:0]  fifo_head, wr_word;
  logic [FRAME_W-1:0] frame_sel;
  logic [N_LANES-1:0] lane_bits;
  logic               start_ok;

  assign wr_word   = {trigger_content_BCID_input, phi_id_input, bandid_input};
  assign fifo_push = load_input && !fifo_full;

  strip_trig_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_320M (clk_320M),
    .reset    (reset),
    .push     (fifo_push),
    .wr_data  (wr_word),
    .pop      (fifo_pop),
    .rd_data  (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Queued words win over the test pattern; padding sits at the LSB end.
  assign start_ok = !fifo_empty || test_mode;

  always_comb begin
    frame_sel = '0;
    frame_sel[FRAME_W-1 -: WORD_W] = fifo_empty ? TEST_PATTERN : fifo_head;
  end

  // Lane k carries the k-th most significant bit of the current slice.
  always_comb begin
    lane_bits = '0;
    for (int k = 0; k < N_LANES; k++) lane_bits[k] = shreg_q[FRAME_W-1-k];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    trig_en_d = 1'b0;
    trig_d_d  = '0;
    fifo_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d  = ST_LOAD;
          shreg_d  = frame_sel;
          fifo_pop = !fifo_empty;
        end
      end
      ST_LOAD: begin
        state_d   = ST_SHIFT;
        cnt_d     = SHIFT_LAST;
        trig_en_d = 1'b1;
        trig_d_d  = lane_bits;
        shreg_d   = shreg_q << N_LANES;
      end
      ST_SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d     = cnt_q - CNT_W'(1);
          trig_en_d = 1'b1;
          trig_d_d  = lane_bits;
          shreg_d   = shreg_q << N_LANES;
        end else begin
          state_d = ST_GAP;
          cnt_d   = GAP_LAST;
        end
      end
      ST_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (start_ok) begin
          state_d  = ST_LOAD;
          shreg_d  = frame_sel;
          fifo_pop = !fifo_empty;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (load_input && fifo_full && (ovf_q != 16'hFFFF)) ovf_d = ovf_q + 16'd1;
  end

  always_ff @(posedge clk_320M) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      trig_en_q <= 1'b0;
      trig_d_q  <= '0;
      ovf_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      trig_en_q <= trig_en_d;
      trig_d_q  <= trig_d_d;
      ovf_q     <= ovf_d;
    end
  end

  assign ready        = !fifo_full;
  assign busy         = (state_q != ST_IDLE) || !fifo_empty;
  assign trig_en      = trig_en_q;
  assign trig_d       = trig_d_q;
  assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_strip_trigger_serializer_multi.sv
module tb_strip_trigger_serializer_multi;

  localparam int BPL2  = 13;
  localparam int GAP   = 1;
  localparam int DEPTH = 4;
  localparam logic [24:0] TEST_PAT = 25'h1555555;
  localparam logic [24:0] W1 = {12'hAC5, 5'h1F, 8'hFF};

  logic        clk_320M = 1'b0;
  logic        reset, load2, load1, load4, tm, tm_aux;
  logic [11:0] bcid;
  logic [4:0]  phi;
  logic [7:0]  band;

  logic        ready2, busy2, en2, ready1, busy1, en1, ready4, busy4, en4;
  logic [1:0]  d2;
  logic [0:0]  d1;
  logic [3:0]  d4;
  logic [15:0] ovf2, ovf1, ovf4;

  always #2 clk_320M = ~clk_320M;

  strip_trigger_serializer_multi #(.N_LANES(2)) u_dut2 (
    .clk_320M(clk_320M), .reset(reset), .load_input(load2),
    .trigger_content_BCID_input(bcid), .phi_id_input(phi), .bandid_input(band),
    .test_mode(tm), .ready(ready2), .busy(busy2), .trig_en(en2), .trig_d(d2),
    .overflow_cnt(ovf2));

  strip_trigger_serializer_multi #(.N_LANES(1)) u_dut1 (
    .clk_320M(clk_320M), .reset(reset), .load_input(load1),
    .trigger_content_BCID_input(bcid), .phi_id_input(phi), .bandid_input(band),
    .test_mode(tm_aux), .ready(ready1), .busy(busy1), .trig_en(en1), .trig_d(d1),
    .overflow_cnt(ovf1));

  strip_trigger_serializer_multi #(.N_LANES(4)) u_dut4 (
    .clk_320M(clk_320M), .reset(reset), .load_input(load4),
    .trigger_content_BCID_input(bcid), .phi_id_input(phi), .bandid_input(band),
    .test_mode(tm_aux), .ready(ready4), .busy(busy4), .trig_en(en4), .trig_d(d4),
    .overflow_cnt(ovf4));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Lane k in frame cycle c carries frame bit (c*n+k) counted from the MSB;
  // anything past the 25-bit word is padding.
  function automatic logic [7:0] exp_lanes(input logic [24:0] w, input int n, input int c);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < n; k++) begin
      int i;
      i = c * n + k;
      if (i < 25) r[k] = w[24 - i];
    end
    return r;
  endfunction

  // Reference model: queue of words plus "cycles since the current frame's
  // load cycle" (0 = load, 1..BPL = data, then the gap).
  logic [24:0] q[$];
  logic [24:0] cur;
  bit          act;
  int          ph;
  int          ovf_m;

  // Observation of trig_en runs on the 2-lane instance.
  int frames, hi_cnt, low_run;
  bit seen_hi, prev_en;
  int gaps[$];

  task automatic clr_trk();
    frames = 0; hi_cnt = 0; low_run = 0; seen_hi = 0; prev_en = 0;
    gaps.delete();
  endtask

  task automatic cyc(input bit rst, input bit ld, input logic [24:0] w, input bit t);
    bit         rdy_pre, launch, exp_en;
    logic [7:0] e8;
    reset = rst; load2 = ld; {bcid, phi, band} = w; tm = t;
    @(posedge clk_320M);
    if (rst) begin
      q.delete(); act = 0; ph = 0; ovf_m = 0;
    end else begin
      rdy_pre = (q.size() < DEPTH);
      launch  = 0;
      if (!act) launch = (q.size() > 0) || t;
      else if (ph == BPL2 + GAP) begin
        launch = (q.size() > 0) || t;
        if (!launch) act = 0;
      end else ph++;
      if (launch) begin
        cur = (q.size() > 0) ? q.pop_front() : TEST_PAT;
        act = 1;
        ph  = 0;
      end
      if (ld) begin
        if (rdy_pre) q.push_back(w);
        else if (ovf_m < 65535) ovf_m++;
      end
    end
    #1;
    exp_en = act && (ph >= 1) && (ph <= BPL2);
    e8 = exp_en ? exp_lanes(cur, 2, ph - 1) : 8'h00;
    chk("trig_en", en2, exp_en);
    chk("trig_d", d2, e8[1:0]);
    chk("ready", ready2, q.size() < DEPTH);
    chk("busy", busy2, act || (q.size() > 0));
    chk("overflow_cnt", ovf2, ovf_m);
    if (en2) begin
      if (!prev_en) begin
        frames++;
        if (seen_hi) gaps.push_back(low_run);
      end
      seen_hi = 1; low_run = 0; hi_cnt++;
    end else if (seen_hi) low_run++;
    prev_en = en2;
  endtask

  initial begin
    logic [24:0] w;
    logic [12:0] l0, l1;
    logic [3:0]  d4_last;
    int first_hi, c1, c4, dens;
    bit t;

    load1 = 0; load4 = 0; tm_aux = 0;
    q.delete(); act = 0; ph = 0; ovf_m = 0; cur = '0;

    // 1: single word, latency, lane contents
    repeat (3) cyc(1, 0, '0, 0);
    chk("rst_en", en2, 0);
    chk("rst_ready", ready2, 1);
    clr_trk();
    cyc(0, 1, W1, 0);
    first_hi = -1; l0 = '0; l1 = '0;
    for (int i = 1; i <= 30; i++) begin
      cyc(0, 0, '0, 0);
      if (en2) begin
        if (first_hi < 0) first_hi = i;
        l0 = {l0[11:0], d2[0]};
        l1 = {l1[11:0], d2[1]};
      end
    end
    chk("t1_latency", first_hi, 2);
    chk("t1_len", hi_cnt, 13);
    chk("t1_lane0", l0, 13'b1110001111111);
    chk("t1_lane1", l1, 13'b0010111111110);

    // 2: back-to-back loads from idle. The first word leaves the FIFO on the
    // next edge, so five are stored and the sixth is dropped.
    cyc(1, 0, '0, 0);
    clr_trk();
    for (int i = 0; i < 6; i++) cyc(0, 1, 25'($urandom), 0);
    repeat (90) cyc(0, 0, '0, 0);
    chk("t2_ovf", ovf2, 1);
    chk("t2_frames", frames, 5);
    chk("t2_ngaps", gaps.size(), 4);
    foreach (gaps[i]) chk("t2_gap", gaps[i], 2);

    // 3: one- and four-lane builds, same word
    cyc(1, 0, '0, 0);
    load1 = 1; load4 = 1;
    cyc(0, 0, W1, 0);
    load1 = 0; load4 = 0;
    c1 = 0; c4 = 0; d4_last = '1;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] e;
      cyc(0, 0, '0, 0);
      e = en1 ? exp_lanes(W1, 1, c1) : 8'h00;
      chk("t3_n1_d", d1, e[0:0]);
      if (en1) c1++;
      e = en4 ? exp_lanes(W1, 4, c4) : 8'h00;
      chk("t3_n4_d", d4, e[3:0]);
      if (en4) begin
        if (c4 == 6) d4_last = d4;
        c4++;
      end
    end
    chk("t3_n1_len", c1, 25);
    chk("t3_n4_len", c4, 7);
    chk("t3_n4_pad", d4_last[3:1], 3'b000);

    // 4: test mode stream with a word injected mid-stream
    cyc(1, 0, '0, 0);
    repeat (40) cyc(0, 0, '0, 1);
    cyc(0, 1, 25'($urandom), 1);
    repeat (60) cyc(0, 0, '0, 1);
    repeat (30) cyc(0, 0, '0, 0);

    // 5: reset in the middle of a frame with words queued
    cyc(1, 0, '0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 1, 25'($urandom), 0);
    chk("t5_ovf_pre", ovf2, 2);
    clr_trk();
    for (int i = 0; i < 50 && hi_cnt < 5; i++) cyc(0, 0, '0, 0);
    chk("t5_reach", hi_cnt, 5);
    cyc(1, 0, '0, 0);
    chk("t5_en", en2, 0);
    chk("t5_d", d2, 0);
    chk("t5_busy", busy2, 0);
    chk("t5_ready", ready2, 1);
    chk("t5_ovf", ovf2, 0);
    clr_trk();
    repeat (40) cyc(0, 0, '0, 0);
    chk("t5_frames", frames, 0);

    // random traffic with varying load density, test_mode and resets
    t = 0; dens = 10;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        dens = (i % 600 == 0) ? 10 : ((i % 400 == 0) ? 90 : 50);
        t = ($urandom_range(0, 2) == 0);
      end
      w = 25'($urandom);
      cyc($urandom_range(0, 399) == 0, $urandom_range(0, 99) < dens, w, t);
    end

    // 6: saturation of the drop counter under continuous loads
    cyc(1, 0, '0, 0);
    for (int i = 0; i < 72000; i++) cyc(0, 1, 25'($urandom), 0);
    chk("t6_sat", ovf2, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
